// File: rtl/spart_bus_ctrl_if.sv
// Byte-stream and SPART bus handshake signals between the controller and its neighbours.
// master = the controller; slave = SPART plus user logic seen from outside.
interface spart_bus_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (
    input  tx_data, tx_valid, rx_ready, rda, tbr,
    output tx_ready, rx_data, rx_valid, iocs, iorw, ioaddr
  );

  modport slave (
    output tx_data, tx_valid, rx_ready, rda, tbr,
    input  tx_ready, rx_data, rx_valid, iocs, iorw, ioaddr
  );
endinterface

// File: rtl/spart_bus_ctrl.sv
// SPART bus master: programs the baud divisor, then round-robins between draining RX
// into a one-entry holding register and feeding TX bytes from a small FIFO.
module spart_bus_ctrl #(
  parameter int TX_DEPTH   = 4,
  parameter int TX_BUSY_TO = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  output logic       cfg_done,
  inout  wire  [7:0] databus,
  spart_bus_ctrl_if.master bus
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = $clog2(TX_BUSY_TO + 1);

  typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RX_READ, TX_WRITE, TX_WAIT} state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_mem [TX_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic [1:0]    r_cfg_q;
  logic          r_cfg_done;
  logic          r_last_tx;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic [CW-1:0] r_wait_cnt;

  logic [15:0]   w_div;
  logic          w_full, w_empty, w_push, w_pop, w_rx_req, w_tx_req;
  logic          w_iocs, w_iorw, w_drive;
  logic [1:0]    w_ioaddr;
  logic [7:0]    w_wdata;

  always_comb begin
    case (br_cfg)
      2'b00:   w_div = 16'h12C0;
      2'b01:   w_div = 16'h2580;
      2'b10:   w_div = 16'h4B00;
      default: w_div = 16'h9600;
    endcase
  end

  assign w_full   = (r_count == (AW+1)'(TX_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = bus.tx_valid && bus.tx_ready;
  assign w_pop    = (r_state == TX_WRITE);
  assign w_rx_req = bus.rda && !r_rx_valid;
  assign w_tx_req = bus.tbr && !w_empty;

  always_comb begin
    w_next   = r_state;
    w_iocs   = 1'b0;
    w_iorw   = 1'b1;
    w_ioaddr = 2'b00;
    w_wdata  = 8'h00;
    case (r_state)
      CFG_LO: begin
        w_iocs = 1'b1; w_iorw = 1'b0; w_ioaddr = 2'b10; w_wdata = w_div[7:0];
        w_next = CFG_HI;
      end
      CFG_HI: begin
        w_iocs = 1'b1; w_iorw = 1'b0; w_ioaddr = 2'b11; w_wdata = w_div[15:8];
        w_next = IDLE;
      end
      IDLE: begin
        // Contention goes to whichever service was not granted last.
        if (br_cfg != r_cfg_q)                   w_next = CFG_LO;
        else if (w_rx_req && (!w_tx_req || r_last_tx)) w_next = RX_READ;
        else if (w_tx_req)                       w_next = TX_WRITE;
      end
      RX_READ: begin
        w_iocs = 1'b1;
        w_next = IDLE;
      end
      TX_WRITE: begin
        w_iocs = 1'b1; w_iorw = 1'b0; w_wdata = r_mem[r_rptr];
        w_next = TX_WAIT;
      end
      TX_WAIT: begin
        if (!bus.tbr || r_wait_cnt == CW'(TX_BUSY_TO - 1)) w_next = IDLE;
      end
      default: w_next = CFG_LO;
    endcase
  end

  // Reset gates the bus pins directly so an access in flight is released at once.
  assign w_drive    = w_iocs && !w_iorw && !rst;
  assign bus.iocs   = w_iocs && !rst;
  assign bus.iorw   = w_iorw || rst;
  assign bus.ioaddr = rst ? 2'b00 : w_ioaddr;
  assign databus    = w_drive ? w_wdata : 8'hzz;

  assign bus.tx_ready = r_cfg_done && !w_full;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign cfg_done     = r_cfg_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= CFG_LO;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_q    <= 2'b00;
      r_cfg_done <= 1'b0;
    end else if (r_state == CFG_HI) begin
      r_cfg_q    <= br_cfg;
      r_cfg_done <= 1'b1;
    end else if (r_state == IDLE && br_cfg != r_cfg_q) begin
      r_cfg_done <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_last_tx <= 1'b1;
    else if (r_state == RX_READ)    r_last_tx <= 1'b0;
    else if (r_state == TX_WRITE)   r_last_tx <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else if (r_state == RX_READ) begin
      r_rx_data  <= databus;
      r_rx_valid <= 1'b1;
    end else if (r_rx_valid && bus.rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_wait_cnt <= '0;
    else if (r_state == TX_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
    else                         r_wait_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Directed sequence with random payloads; a SPART bus model logs every access and
// expected traffic is derived from baud arithmetic, byte queues and service order.
module tb_spart_bus_ctrl;
  localparam int TX_BUSY_TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b01;
  logic       cfg_done;
  wire  [7:0] databus;

  spart_bus_ctrl_if bus();

  spart_bus_ctrl #(.TX_DEPTH(4), .TX_BUSY_TO(TX_BUSY_TO)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .cfg_done(cfg_done),
    .databus(databus), .bus(bus)
  );

  always #10 clk = ~clk;

  // SPART side: answers reads with spart_q; in auto mode tbr drops for the cycle after a TX write.
  logic [7:0] spart_q  = 8'h00;
  logic       tbr_auto = 1'b0;
  logic       tbr_lvl  = 1'b0;
  logic       r_wrote  = 1'b0;
  always @(posedge clk) r_wrote <= bus.iocs && !bus.iorw && bus.ioaddr == 2'b00;
  assign bus.tbr = tbr_auto ? !r_wrote : tbr_lvl;
  assign databus = (bus.iocs && bus.iorw) ? spart_q : 8'hzz;

  typedef struct {logic [10:0] acc; int cyc;} acc_t;
  acc_t log_q[$];
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.iocs === 1'b1) log_q.push_back('{{bus.iorw, bus.ioaddr, databus}, cyc});

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] divisor(input logic [1:0] br);
    return 16'(4800 << br);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b, output bit ok);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (bus.tx_ready) ok = 1'b1;
      @(negedge clk);
    end
    bus.tx_valid = 1'b0;
  endtask

  task automatic check_cfg(input string tag, input int base, input logic [1:0] br);
    logic [15:0] dv;
    dv = divisor(br);
    chk({tag, "_n"}, 32'(log_q.size() - base), 32'd2);
    chk({tag, "_lo"}, 32'(log_q[base].acc),     32'({1'b0, 2'b10, dv[7:0]}));
    chk({tag, "_hi"}, 32'(log_q[base + 1].acc), 32'({1'b0, 2'b11, dv[15:8]}));
  endtask

  task automatic check_tx(input string tag, input int base, input logic [7:0] exp[$]);
    int k = 0;
    for (int i = base; i < log_q.size(); i++)
      if (log_q[i].acc[10:8] == 3'b000) begin
        if (k < exp.size()) chk(tag, 32'(log_q[i].acc[7:0]), 32'(exp[k]));
        k++;
      end
    chk({tag, "_n"}, 32'(k), 32'(exp.size()));
  endtask

  function automatic int count_reads(input int base);
    int n = 0;
    for (int i = base; i < log_q.size(); i++) if (log_q[i].acc[10:8] == 3'b100) n++;
    return n;
  endfunction

  initial begin
    bit         ok;
    int         base;
    logic [7:0] b;
    logic [7:0] exp_tx[$];
    bit         last_rx;
    bit         want_rx;
    int         k;
    int         wcyc[$];

    bus.tx_data = 8'h00; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0; bus.rda = 1'b0;

    // Reset values and divisor programming
    cycles(2);
    chk("rst_iocs", 32'(bus.iocs), 32'd0);
    chk("rst_iorw", 32'(bus.iorw), 32'd1);
    chk("rst_ioaddr", 32'(bus.ioaddr), 32'd0);
    chk("rst_cfg_done", 32'(cfg_done), 32'd0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
    chk("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
    checks++;
    assert (databus === 8'hzz) else begin
      errors++; $error("FAIL rst_databus: observed %0h expected zz", databus);
    end
    base = log_q.size();
    tbr_auto = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("cfg_done_1cyc", 32'(cfg_done), 32'd0);
    @(negedge clk);
    chk("cfg_done_2cyc", 32'(cfg_done), 32'd1);
    chk("cfg_tx_ready", 32'(bus.tx_ready), 32'd1);
    check_cfg("cfg", base, 2'b01);

    // TX stream in order, tbr dropping after each write
    base = log_q.size();
    for (int i = 0; i < 6; i++) begin
      b = (i == 0) ? 8'h41 : (i == 1) ? 8'h42 : 8'($urandom);
      push(b, ok);
      chk("tx_push", 32'(ok), 32'd1);
      exp_tx.push_back(b);
    end
    cycles(40);
    check_tx("tx_order", base, exp_tx);
    last_rx = 1'b0;

    // RX holding register blocks further reads until consumed
    base = log_q.size();
    b = 8'($urandom);
    spart_q = b;
    bus.rda = 1'b1;
    @(negedge clk);
    chk("rx_lat1", 32'(bus.rx_valid), 32'd0);
    @(negedge clk);
    chk("rx_lat2", 32'(bus.rx_valid), 32'd1);
    chk("rx_data", 32'(bus.rx_data), 32'(b));
    cycles(8);
    chk("rx_hold", 32'(bus.rx_data), 32'(b));
    chk("rx_one_read", 32'(count_reads(base)), 32'd1);
    for (int j = 0; j < 3; j++) begin
      b = 8'($urandom);
      spart_q = b;
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
      chk("rx_clear", 32'(bus.rx_valid), 32'd0);
      for (int i = 0; i < 10 && !bus.rx_valid; i++) @(negedge clk);
      chk("rx_valid_next", 32'(bus.rx_valid), 32'd1);
      chk("rx_data_next", 32'(bus.rx_data), 32'(b));
    end
    chk("rx_reads", 32'(count_reads(base)), 32'd4);
    bus.rda = 1'b0;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    last_rx = 1'b1;

    // Round-robin with both services pending continuously
    tbr_auto = 1'b0; tbr_lvl = 1'b0;
    exp_tx = {};
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom); push(b, ok); chk("alt_push", 32'(ok), 32'd1); exp_tx.push_back(b);
    end
    base = log_q.size();
    spart_q = 8'($urandom);
    bus.rx_ready = 1'b1;
    bus.rda = 1'b1;
    tbr_auto = 1'b1;
    cycles(30);
    want_rx = !last_rx;
    k = 0;
    for (int i = base; i < log_q.size() && k < 6; i++)
      if (log_q[i].acc[9:8] == 2'b00) begin
        chk("alt_order", 32'(log_q[i].acc[10]), 32'(want_rx));
        want_rx = !want_rx;
        k++;
      end
    chk("alt_n", 32'(k), 32'd6);
    check_tx("alt_tx", base, exp_tx);
    bus.rda = 1'b0;
    cycles(3);
    bus.rx_ready = 1'b0;

    // FIFO full and TX_WAIT timeout with tbr stuck high
    tbr_auto = 1'b0; tbr_lvl = 1'b0;
    exp_tx = {};
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom); push(b, ok); chk("full_push", 32'(ok), 32'd1); exp_tx.push_back(b);
    end
    chk("full_ready", 32'(bus.tx_ready), 32'd0);
    bus.tx_data = 8'($urandom);
    bus.tx_valid = 1'b1;
    cycles(3);
    chk("full_hold", 32'(bus.tx_ready), 32'd0);
    bus.tx_valid = 1'b0;
    base = log_q.size();
    tbr_lvl = 1'b1;
    cycles(4 * (TX_BUSY_TO + 2) + 6);
    check_tx("to_tx", base, exp_tx);
    for (int i = base; i < log_q.size(); i++)
      if (log_q[i].acc[10:8] == 3'b000) wcyc.push_back(log_q[i].cyc);
    for (int i = 1; i < wcyc.size(); i++)
      chk("to_gap", 32'(wcyc[i] - wcyc[i-1]), 32'(TX_BUSY_TO + 2));
    tbr_lvl = 1'b0;
    cycles(3);

    // Reconfiguration keeps queued TX bytes
    exp_tx = {};
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom); push(b, ok); chk("recfg_push", 32'(ok), 32'd1); exp_tx.push_back(b);
    end
    base = log_q.size();
    br_cfg = 2'b11;
    @(negedge clk);
    chk("recfg_drop", 32'(cfg_done), 32'd0);
    chk("recfg_tx_ready", 32'(bus.tx_ready), 32'd0);
    cycles(2);
    chk("recfg_done", 32'(cfg_done), 32'd1);
    check_cfg("recfg", base, 2'b11);
    tbr_auto = 1'b1;
    cycles(15);
    check_tx("recfg_tx", base, exp_tx);

    // Reset in the middle of a divisor write
    br_cfg = 2'b10;
    @(negedge clk);
    chk("mid_iocs", 32'(bus.iocs), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_iocs", 32'(bus.iocs), 32'd0);
    chk("mid_rst_iorw", 32'(bus.iorw), 32'd1);
    chk("mid_rst_cfg_done", 32'(cfg_done), 32'd0);
    checks++;
    assert (databus === 8'hzz) else begin
      errors++; $error("FAIL mid_rst_databus: observed %0h expected zz", databus);
    end
    @(negedge clk);
    base = log_q.size();
    rst = 1'b0;
    cycles(2);
    chk("post_rst_done", 32'(cfg_done), 32'd1);
    check_cfg("post_rst", base, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
